mem_arb: RTL and testbench

//  - N-channel memory front end: round-robin arbitrates NUM_CH processor memory ports onto one synchronous SRAM.
//  - Converts byte/half/word accesses to lane selects; pipelined, one access issued per cycle.
//  - Sits between N packet-processor instances and the shared packet SRAM.

---
 rtl/mem_arb_pkg.sv | 60 ++++++
 rtl/mem_arb_rr_arbiter.sv | 55 +++++
 rtl/mem_arb.sv | 171 +++++++++++++++++
 tb/tb_mem_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: access-width codes, the
// lane-decode result type and helpers that turn (width, byte offset) into SRAM
// byte-lane enables and a right-aligned data mask.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int LANES = 4;

    // Access size codes as presented on ch_width_i (size in bytes)
    localparam logic [3:0] W_BYTE = 4'd1;
    localparam logic [3:0] W_HALF = 4'd2;
    localparam logic [3:0] W_WORD = 4'd4;

    typedef struct packed {
        logic             legal;
        logic [LANES-1:0] sel;
    } lane_t;

    // Alignment check plus lane select; anything not a legal size/offset pair
    // comes back with legal=0 and no lanes enabled.
    function automatic lane_t laneDecode(input logic [3:0] width, input logic [1:0] offs);
        lane_t r;
        r.legal = 1'b0;
        r.sel   = '0;
        case (width)
            W_BYTE: begin
                r.legal = 1'b1;
                r.sel   = 4'b0001 << offs;
            end
            W_HALF: begin
                if (!offs[0]) begin
                    r.legal = 1'b1;
                    r.sel   = 4'b0011 << offs;
                end
            end
            W_WORD: begin
                if (offs == 2'b00) begin
                    r.legal = 1'b1;
                    r.sel   = 4'b1111;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Right-aligned mask covering the bytes of an access of the given size
    function automatic logic [31:0] widthMask(input logic [3:0] width);
        logic [31:0] m;
        case (width)
            W_BYTE:  m = 32'h0000_00FF;
            W_HALF:  m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: picks the first unmasked requester at or after the
// rotating pointer, then moves the pointer to one past the winner.
// Ports:
//   clk, rst          clock, synchronous active-low reset (pointer -> 0)
//   i_req[NUM_CH]     request vector
//   i_mask[NUM_CH]    channels excluded from this cycle's arbitration
//   o_gnt[NUM_CH]     one-hot grant (zero when nobody eligible)
//   o_gntIdx[CH_W]    index of the granted channel
//   o_gntValid        a grant was made this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic [NUM_CH-1:0] i_mask,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gntIdx,
    output logic              o_gntValid
);

    logic [CH_W-1:0]   r_ptr;
    logic [NUM_CH-1:0] w_elig;

    // Scan from the pointer around the ring; the first eligible channel wins
    always_comb begin
        w_elig     = i_req & ~i_mask;
        o_gntValid = 1'b0;
        o_gntIdx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!o_gntValid && w_elig[CH_W'((int'(r_ptr) + k) % NUM_CH)]) begin
                o_gntValid = 1'b1;
                o_gntIdx   = CH_W'((int'(r_ptr) + k) % NUM_CH);
            end
        end
        o_gnt = o_gntValid ? (NUM_CH'(1) << o_gntIdx) : '0;
    end

    // Pointer only moves when something is granted, so idle cycles keep the
    // rotation where it was
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (o_gntValid) begin
            r_ptr <= (o_gntIdx == CH_W'(NUM_CH - 1)) ? '0 : o_gntIdx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// N-channel memory front end: round-robin arbitrates NUM_CH processor ports
// onto one synchronous SRAM, one access issued per cycle. The issue cycle
// drives the SRAM combinationally from the winner; the following cycle acks
// the winner and returns right-aligned, zero-extended read data.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   ch_ce_i/we_i/addr_i/width_i/data_i   per-channel request (held until ack)
//   ch_ack_o, ch_err_o             one-hot completion pulse, error subset
//   ch_data_o                      read data, valid with ack
//   sram_ce/we/addr_o/sel_o/data_o SRAM command (word address, lane enables)
//   sram_data_i                    SRAM read data, valid cycle after sram_ce
//   stat_grant_o, stat_conf_o      only with MEM_ARB_STATS_EN: saturating
//                                  per-channel grant and conflict counters
// Build option: define MEM_ARB_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_ce_i,
    input  logic [NUM_CH-1:0]        ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*4-1:0]      ch_width_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic [NUM_CH-1:0]        ch_err_o,
    output logic [DATA_W-1:0]        ch_data_o,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_W-1:0]        sram_addr_o,
    output logic [3:0]               sram_sel_o,
    output logic [DATA_W-1:0]        sram_data_o,
    input  logic [DATA_W-1:0]        sram_data_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]     stat_grant_o,
    output logic [15:0]              stat_conf_o
`endif
);

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_gntIdx;
    logic              w_gntValid;
    logic              w_selWe;
    logic [ADDR_W-1:0] w_selAddr;
    logic [3:0]        w_selWidth;
    logic [DATA_W-1:0] w_selData;
    lane_t             w_lane;
    logic              w_issue;

    logic              r_respValid;
    logic [CH_W-1:0]   r_respCh;
    logic              r_respErr;
    logic              r_respRd;
    logic [1:0]        r_respOffs;
    logic [3:0]        r_respWidth;

    // Requests are ignored while reset is low so nothing reaches the SRAM.
    // The channel currently being acked still holds ce this cycle, so it is
    // masked to avoid granting a stale request twice.
    assign w_req  = ch_ce_i & {NUM_CH{rst}};
    assign w_mask = r_respValid ? (NUM_CH'(1) << r_respCh) : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      (w_req),
        .i_mask     (w_mask),
        .o_gnt      (w_gnt),
        .o_gntIdx   (w_gntIdx),
        .o_gntValid (w_gntValid)
    );

    // Issue mux: AND-OR select of the winning channel's request fields
    always_comb begin
        w_selWe    = 1'b0;
        w_selAddr  = '0;
        w_selWidth = '0;
        w_selData  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt[c]) begin
                w_selWe    = ch_we_i[c];
                w_selAddr  = ch_addr_i[c*ADDR_W +: ADDR_W];
                w_selWidth = ch_width_i[c*4 +: 4];
                w_selData  = ch_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    // Illegal accesses still win arbitration (and get an error ack) but never
    // touch the SRAM; all command fields idle at zero when nothing issues.
    always_comb begin
        w_lane      = laneDecode(w_selWidth, w_selAddr[1:0]);
        w_issue     = w_gntValid && w_lane.legal;
        sram_ce     = w_issue;
        sram_we     = w_issue && w_selWe;
        sram_addr_o = w_issue ? {2'b00, w_selAddr[ADDR_W-1:2]} : '0;
        sram_sel_o  = w_issue ? w_lane.sel : '0;
        sram_data_o = w_issue ? ((w_selData & widthMask(w_selWidth)) << {w_selAddr[1:0], 3'b000}) : '0;
    end

    // One-entry response stage: remembers who was granted and how to align
    // the read data coming back from the SRAM next cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_respValid <= 1'b0;
            r_respCh    <= '0;
            r_respErr   <= 1'b0;
            r_respRd    <= 1'b0;
            r_respOffs  <= '0;
            r_respWidth <= '0;
        end else begin
            r_respValid <= w_gntValid;
            r_respCh    <= w_gntIdx;
            r_respErr   <= w_gntValid && !w_lane.legal;
            r_respRd    <= !w_selWe;
            r_respOffs  <= w_selAddr[1:0];
            r_respWidth <= w_selWidth;
        end
    end

    // Responses are also gated by rst so an access in flight when reset
    // arrives never shows its ack
    always_comb begin
        ch_ack_o  = (r_respValid && rst) ? (NUM_CH'(1) << r_respCh) : '0;
        ch_err_o  = (r_respValid && rst && r_respErr) ? (NUM_CH'(1) << r_respCh) : '0;
        ch_data_o = (r_respValid && rst && !r_respErr && r_respRd)
                    ? ((sram_data_i >> {r_respOffs, 3'b000}) & widthMask(r_respWidth))
                    : '0;
    end

`ifdef MEM_ARB_STATS_EN
    logic [NUM_CH-1:0][15:0] r_grantCnt;
    logic [15:0]             r_confCnt;

    // Saturating grant and contention counters (contention = more than one
    // live request in a cycle, regardless of masking)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grantCnt <= '0;
            r_confCnt  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_gnt[c] && r_grantCnt[c] != 16'hFFFF) begin
                    r_grantCnt[c] <= r_grantCnt[c] + 16'd1;
                end
            end
            if ($countones(w_req) > 1 && r_confCnt != 16'hFFFF) begin
                r_confCnt <= r_confCnt + 16'd1;
            end
        end
    end

    assign stat_grant_o = r_grantCnt;
    assign stat_conf_o  = r_confCnt;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
// Self-checking bench for mem_arb with a behavioural SRAM. Single-channel
// accesses come from a vector table; arbitration order, reset and (when
// MEM_ARB_STATS_EN is defined) the statistics counters use short sequences.
// Expected acks are queued at issue time and compared a cycle later.
// -----------------------------------------------------------------------------
module tb_mem_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_ce_i, ch_we_i, ch_ack_o, ch_err_o;
    logic [127:0] ch_addr_i, ch_data_i;
    logic [15:0]  ch_width_i;
    logic [31:0]  ch_data_o, sram_addr_o, sram_data_o, sram_data_i;
    logic         sram_ce, sram_we;
    logic [3:0]   sram_sel_o;
`ifdef MEM_ARB_STATS_EN
    logic [63:0]  stat_grant_o;
    logic [15:0]  stat_conf_o;
`endif

    always #5 clk = ~clk;

    mem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .ch_ce_i     (ch_ce_i),
        .ch_we_i     (ch_we_i),
        .ch_addr_i   (ch_addr_i),
        .ch_width_i  (ch_width_i),
        .ch_data_i   (ch_data_i),
        .ch_ack_o    (ch_ack_o),
        .ch_err_o    (ch_err_o),
        .ch_data_o   (ch_data_o),
        .sram_ce     (sram_ce),
        .sram_we     (sram_we),
        .sram_addr_o (sram_addr_o),
        .sram_sel_o  (sram_sel_o),
        .sram_data_o (sram_data_o),
        .sram_data_i (sram_data_i)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grant_o(stat_grant_o),
        .stat_conf_o (stat_conf_o)
`endif
    );

    // Behavioural SRAM: 64 words, byte-lane writes, one-cycle read latency.
    // Reset reloads the preset contents.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]      <= 32'hA1B2_C3D4;
            sram_data_i <= 32'h0;
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_sel_o[b]) mem[sram_addr_o[5:0]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
                end
            end else begin
                sram_data_i <= mem[sram_addr_o[5:0]];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] data;
    } resp_t;
    resp_t expQ[$];

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] wdata;
        logic        expCe;
        logic [31:0] expAddr;
        logic [3:0]  expSel;
        logic [31:0] expSdata;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs[15];

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pushResp(input int ch, input logic err, input logic [31:0] data);
        resp_t e;
        e.ch   = ch;
        e.err  = err;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Compares the response outputs against the entry queued last cycle;
    // an empty queue means no ack is allowed this cycle
    task automatic checkOutput(input string name);
        resp_t      e;
        logic       vld;
        logic [3:0] expAck;
        logic [3:0] expErr;
        vld = 1'b0;
        e.ch = 0; e.err = 1'b0; e.data = 32'h0;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            vld = 1'b1;
        end
        expAck = vld ? 4'(1 << e.ch) : 4'b0;
        expErr = (vld && e.err) ? expAck : 4'b0;
        expectEq({name, ".ack"},  32'(ch_ack_o), 32'(expAck));
        expectEq({name, ".err"},  32'(ch_err_o), 32'(expErr));
        expectEq({name, ".data"}, ch_data_o, vld ? e.data : 32'h0);
    endtask

    task automatic setCh(input int c, input logic ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] w, input logic [31:0] d);
        ch_ce_i[2'(c)]           = ce;
        ch_we_i[2'(c)]           = we;
        ch_addr_i[7'(c*32) +: 32] = addr;
        ch_width_i[4'(c*4) +: 4] = w;
        ch_data_i[7'(c*32) +: 32] = d;
    endtask

    task automatic clearAll();
        ch_ce_i = '0; ch_we_i = '0; ch_addr_i = '0; ch_width_i = '0; ch_data_i = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One table vector: issue cycle (SRAM command checked), then idle ack cycle
    task automatic applyStimulus(input int idx);
        vec_t  v;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        clearAll();
        setCh(v.ch, 1'b1, v.we, v.addr, v.width, v.wdata);
        @(negedge clk);
        checkOutput({nm, ".pre"});
        expectEq({nm, ".sram_ce"},   32'(sram_ce), 32'(v.expCe));
        expectEq({nm, ".sram_we"},   32'(sram_we), 32'(v.expCe & v.we));
        expectEq({nm, ".sram_addr"}, sram_addr_o, v.expAddr);
        expectEq({nm, ".sram_sel"},  32'(sram_sel_o), 32'(v.expSel));
        if (v.we && v.expCe) expectEq({nm, ".sram_data"}, sram_data_o, v.expSdata);
        pushResp(v.ch, v.expErr, v.expData);
        nextCycle();
        clearAll();
        @(negedge clk);
        checkOutput({nm, ".resp"});
        expectEq({nm, ".idle_ce"}, 32'(sram_ce), 32'h0);
        nextCycle();
    endtask

    initial begin
        int          fairOrder [8];
        logic [31:0] fairData  [4];
        int          statOrder [5];

        //            ch we addr      w  wdata        ce addr sel      sdata        err data
        vecs[0]  = '{0, 1'b0, 32'h10, 4, 32'h0,        1'b1, 4, 4'b1111, 32'h0,        1'b0, 32'hA1B2C3D4};
        vecs[1]  = '{1, 1'b1, 32'h13, 1, 32'hFFFFFF55, 1'b1, 4, 4'b1000, 32'h55000000, 1'b0, 32'h0};
        vecs[2]  = '{1, 1'b0, 32'h13, 1, 32'h0,        1'b1, 4, 4'b1000, 32'h0,        1'b0, 32'h55};
        vecs[3]  = '{2, 1'b0, 32'h11, 2, 32'h0,        1'b0, 0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[4]  = '{3, 1'b0, 32'h12, 2, 32'h0,        1'b1, 4, 4'b1100, 32'h0,        1'b0, 32'h55B2};
        vecs[5]  = '{0, 1'b1, 32'h22, 2, 32'hCAFEBEEF, 1'b1, 8, 4'b1100, 32'hBEEF0000, 1'b0, 32'h0};
        vecs[6]  = '{2, 1'b0, 32'h20, 4, 32'h0,        1'b1, 8, 4'b1111, 32'h0,        1'b0, 32'hBEEF0000};
        vecs[7]  = '{3, 1'b0, 32'h23, 1, 32'h0,        1'b1, 8, 4'b1000, 32'h0,        1'b0, 32'hBE};
        vecs[8]  = '{0, 1'b0, 32'h20, 3, 32'h0,        1'b0, 0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1, 1'b1, 32'h22, 4, 32'hFFFFFFFF, 1'b0, 0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{2, 1'b1, 32'h1C, 4, 32'h12345678, 1'b1, 7, 4'b1111, 32'h12345678, 1'b0, 32'h0};
        vecs[11] = '{0, 1'b0, 32'h1C, 4, 32'h0,        1'b1, 7, 4'b1111, 32'h0,        1'b0, 32'h12345678};
        vecs[12] = '{1, 1'b0, 32'h1E, 2, 32'h0,        1'b1, 7, 4'b1100, 32'h0,        1'b0, 32'h1234};
        vecs[13] = '{2, 1'b0, 32'h1D, 1, 32'h0,        1'b1, 7, 4'b0010, 32'h0,        1'b0, 32'h56};
        vecs[14] = '{3, 1'b0, 32'h00, 0, 32'h0,        1'b0, 0, 4'b0000, 32'h0,        1'b1, 32'h0};

        fairOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
        fairData  = '{32'h55B2C3D4, 32'h0, 32'h0, 32'h12345678};
        statOrder = '{0, 1, 2, 0, 1};

        // Reset state, with every channel requesting to prove reset blocks issue
        rst = 1'b0;
        clearAll();
        ch_ce_i = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        expectEq("reset.sram_ce",   32'(sram_ce), 32'h0);
        expectEq("reset.sram_addr", sram_addr_o,  32'h0);
        expectEq("reset.sram_sel",  32'(sram_sel_o), 32'h0);
        nextCycle();
        clearAll();
        rst = 1'b1;
        nextCycle();

        // Single-channel accesses, lane decode and error cases
        for (int i = 0; i < 15; i++) applyStimulus(i);

        // All four channels requesting continuously: strict rotation
        clearAll();
        for (int c = 0; c < 4; c++) setCh(c, 1'b1, 1'b0, 32'h10 + 32'(4*c), 4, 32'h0);
        for (int g = 0; g < 8; g++) begin
            @(negedge clk);
            checkOutput($sformatf("fair%0d", g));
            expectEq($sformatf("fair%0d.sram_ce", g), 32'(sram_ce), 32'h1);
            expectEq($sformatf("fair%0d.sram_addr", g), sram_addr_o, 32'(4 + fairOrder[g]));
            pushResp(fairOrder[g], 1'b0, fairData[fairOrder[g]]);
            nextCycle();
        end
        clearAll();
        @(negedge clk);
        checkOutput("fair.tail");
        nextCycle();

        // Reset returns the pointer to 0: ch1 grant leaves pointer at 2
        setCh(1, 1'b1, 1'b0, 32'h10, 4, 32'h0);
        @(negedge clk);
        checkOutput("rstA.pre");
        pushResp(1, 1'b0, 32'h55B2C3D4);
        nextCycle();
        clearAll();
        @(negedge clk);
        checkOutput("rstA.ack1");
        nextCycle();
        rst = 1'b0;
        setCh(2, 1'b1, 1'b0, 32'h10, 4, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstA.hold");
            expectEq("rstA.hold.sram_ce", 32'(sram_ce), 32'h0);
            nextCycle();
        end
        rst = 1'b1;
        setCh(0, 1'b1, 1'b0, 32'h14, 4, 32'h0);
        @(negedge clk);
        checkOutput("rstA.first");
        expectEq("rstA.first.sram_addr", sram_addr_o, 32'd5);
        pushResp(0, 1'b0, 32'h0);
        nextCycle();
        setCh(0, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        @(negedge clk);
        checkOutput("rstA.second");
        expectEq("rstA.second.sram_addr", sram_addr_o, 32'd4);
        pushResp(2, 1'b0, 32'hA1B2C3D4);
        nextCycle();
        clearAll();
        @(negedge clk);
        checkOutput("rstA.tail");
        nextCycle();

        // Reset the cycle after ch3 issues: its ack must never appear
        setCh(3, 1'b1, 1'b0, 32'h10, 4, 32'h0);
        @(negedge clk);
        checkOutput("rstB.pre");
        expectEq("rstB.issue.sram_ce", 32'(sram_ce), 32'h1);
        nextCycle();
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstB.dropped");
            nextCycle();
        end
        rst = 1'b1;
        setCh(0, 1'b1, 1'b0, 32'h14, 4, 32'h0);
        @(negedge clk);
        checkOutput("rstB.first");
        expectEq("rstB.first.sram_addr", sram_addr_o, 32'd5);
        pushResp(0, 1'b0, 32'h0);
        nextCycle();
        setCh(0, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        @(negedge clk);
        checkOutput("rstB.second");
        expectEq("rstB.second.sram_addr", sram_addr_o, 32'd4);
        pushResp(3, 1'b0, 32'hA1B2C3D4);
        nextCycle();
        clearAll();
        @(negedge clk);
        checkOutput("rstB.tail");
        nextCycle();

`ifdef MEM_ARB_STATS_EN
        // Three channels contending for five cycles after a fresh reset
        rst = 1'b0;
        nextCycle();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) setCh(c, 1'b1, 1'b0, 32'h14, 4, 32'h0);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            checkOutput($sformatf("stat%0d", g));
            pushResp(statOrder[g], 1'b0, 32'h0);
            nextCycle();
        end
        clearAll();
        @(negedge clk);
        checkOutput("stat.tail");
        expectEq("stat.conf",   32'(stat_conf_o), 32'd5);
        expectEq("stat.grant0", 32'(stat_grant_o[15:0]),  32'd2);
        expectEq("stat.grant1", 32'(stat_grant_o[31:16]), 32'd2);
        expectEq("stat.grant2", 32'(stat_grant_o[47:32]), 32'd1);
        expectEq("stat.grant3", 32'(stat_grant_o[63:48]), 32'd0);
        expectEq("stat.sum", 32'(stat_grant_o[15:0]) + 32'(stat_grant_o[31:16])
                           + 32'(stat_grant_o[47:32]) + 32'(stat_grant_o[63:48]), 32'd5);
        nextCycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
